// File: rtl/ehgu_hamming_secded_dec.sv
// SECDED Hamming decoder: syndrome/parity stage, then correct/classify stage,
// both elastic with valid/ready, plus saturating error counters for status.
module ehgu_hamming_secded_dec #(
  parameter int unsigned K     = 4,
  parameter int unsigned N     = 7,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N:0]       in_code,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [K-1:0]     out_data,
  output logic             out_sec,
  output logic             out_ded,
  output logic [N-K-1:0]   out_syndrome,
  input  logic             clr_cnt,
  output logic [CNT_W-1:0] cnt_sec,
  output logic [CNT_W-1:0] cnt_ded
);

  localparam int unsigned P = N - K;

  // Code positions covered by syndrome bit j: those whose 1-based index has bit j set.
  function automatic logic [N-1:0] syn_mask(input int unsigned j);
    logic [N-1:0] m;
    m = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if ((((i + 1) >> j) & 1) != 0) m = m | (N'(1) << i);
    end
    return m;
  endfunction

  // Code position of data bit k: k-th index that is not a parity slot (2**j-1).
  function automatic int unsigned data_pos(input int unsigned k);
    int unsigned seen;
    int unsigned pos;
    seen = 0;
    pos  = 0;
    for (int unsigned i = 0; i < N; i++) begin
      if (((i + 1) & i) != 0) begin
        if (seen == k) pos = i;
        seen++;
      end
    end
    return pos;
  endfunction

  logic         rdy_q;
  logic         s1_valid;
  logic [N-1:0] s1_code;
  logic [P-1:0] s1_syn;
  logic         s1_op;

  logic         s1_load;
  logic         s2_load;
  logic         deliver;
  logic [P-1:0] syn_c;
  logic [N-1:0] flip_c;
  logic [N-1:0] corr_c;
  logic [K-1:0] data_c;
  logic         sec_c;
  logic         ded_c;

  // Handshake plumbing: S1 may advance into S2 whenever S2 is empty or draining.
  assign s2_load  = s1_valid && (!out_valid || out_ready);
  assign in_ready = rdy_q && (!s1_valid || s2_load);
  assign s1_load  = in_valid && in_ready;
  assign deliver  = out_valid && out_ready;

  for (genvar j = 0; j < P; j++) begin : g_syn
    localparam logic [N-1:0] MASK = syn_mask(j);
    assign syn_c[j] = ^(in_code[N-1:0] & MASK);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rdy_q    <= 1'b0;
      s1_valid <= 1'b0;
      s1_code  <= '0;
      s1_syn   <= '0;
      s1_op    <= 1'b0;
    end else begin
      rdy_q <= 1'b1;
      if (s1_load) begin
        s1_valid <= 1'b1;
        s1_code  <= in_code[N-1:0];
        s1_syn   <= syn_c;
        s1_op    <= ^in_code;
      end else if (s2_load) begin
        s1_valid <= 1'b0;
      end
    end
  end

  // One-hot flip vector; all-zero when the syndrome points past the code.
  for (genvar i = 0; i < N; i++) begin : g_flip
    assign flip_c[i] = (s1_syn == P'(i + 1));
  end

  always_comb begin
    sec_c  = 1'b0;
    ded_c  = 1'b0;
    corr_c = s1_code;
    if (s1_syn == '0) begin
      sec_c = s1_op;
    end else if (!s1_op || (flip_c == '0)) begin
      ded_c = 1'b1;
    end else begin
      corr_c = s1_code ^ flip_c;
      sec_c  = 1'b1;
    end
  end

  for (genvar k = 0; k < K; k++) begin : g_data
    localparam int unsigned POS = data_pos(k);
    assign data_c[k] = corr_c[POS];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid    <= 1'b0;
      out_data     <= '0;
      out_sec      <= 1'b0;
      out_ded      <= 1'b0;
      out_syndrome <= '0;
    end else if (s2_load) begin
      out_valid    <= 1'b1;
      out_data     <= data_c;
      out_sec      <= sec_c;
      out_ded      <= ded_c;
      out_syndrome <= s1_syn;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  // Status counters advance only on delivered words; clear beats increment.
  always_ff @(posedge clk) begin
    if (rst || clr_cnt) begin
      cnt_sec <= '0;
      cnt_ded <= '0;
    end else begin
      if (deliver && out_sec && (cnt_sec != '1)) cnt_sec <= cnt_sec + CNT_W'(1);
      if (deliver && out_ded && (cnt_ded != '1)) cnt_ded <= cnt_ded + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_ehgu_hamming_secded_dec.sv
// Bench for ehgu_hamming_secded_dec: directed spec vectors plus randomized
// traffic scored against an arithmetic SECDED reference model.
module tb_ehgu_hamming_secded_dec;

  localparam int unsigned K  = 4;
  localparam int unsigned N  = 7;
  localparam int unsigned P  = N - K;
  localparam int unsigned CW = N + 1;
  localparam int unsigned RW = K + P + 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          out_ready = 1'b0;
  logic          clr_cnt = 1'b0;
  logic [N:0]    in_code = '0;

  logic          in_ready, out_valid, out_sec, out_ded;
  logic [K-1:0]  out_data;
  logic [P-1:0]  out_syndrome;
  logic [15:0]   cnt_sec, cnt_ded;

  logic          b_in_ready, b_out_valid, b_out_sec, b_out_ded;
  logic [K-1:0]  b_out_data;
  logic [P-1:0]  b_out_syndrome;
  logic [1:0]    b_cnt_sec, b_cnt_ded;

  int checks = 0;
  int passed = 0;

  logic [RW-1:0] q[$];
  int m16_sec = 0, m16_ded = 0, m2_sec = 0, m2_ded = 0;

  ehgu_hamming_secded_dec #(.K(K), .N(N), .CNT_W(16)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_code(in_code),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_sec(out_sec),
    .out_ded(out_ded), .out_syndrome(out_syndrome), .clr_cnt(clr_cnt),
    .cnt_sec(cnt_sec), .cnt_ded(cnt_ded));

  ehgu_hamming_secded_dec #(.K(K), .N(N), .CNT_W(2)) u_dut2 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(b_in_ready), .in_code(in_code),
    .out_valid(b_out_valid), .out_ready(out_ready), .out_data(b_out_data), .out_sec(b_out_sec),
    .out_ded(b_out_ded), .out_syndrome(b_out_syndrome), .clr_cnt(clr_cnt),
    .cnt_sec(b_cnt_sec), .cnt_ded(b_cnt_ded));

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Reference: syndrome = XOR of 1-based positions of set code bits.
  function automatic logic [RW-1:0] ref_dec(input logic [N:0] code);
    int s;
    logic op, sec, ded;
    logic [N-1:0] fix, tmp;
    logic [K-1:0] d;
    s = 0; op = 1'b0; sec = 1'b0; ded = 1'b0; d = '0;
    op = ^code;
    for (int i = 0; i < int'(N); i++) if (((code >> i) & 1) != 0) s = s ^ (i + 1);
    fix = code[N-1:0];
    if (op && s != 0) begin
      if (s <= int'(N)) begin fix = fix ^ (N'(1) << (s - 1)); sec = 1'b1; end
      else ded = 1'b1;
    end else if (op) begin
      sec = 1'b1;
    end else if (s != 0) begin
      ded = 1'b1;
    end
    for (int i = int'(N) - 1; i >= 0; i--) begin
      if (((i + 1) & i) != 0) begin
        tmp = fix >> i;
        d = {d[K-2:0], tmp[0]};
      end
    end
    return {d, P'(s), sec, ded};
  endfunction

  function automatic logic [N:0] enc(input logic [K-1:0] d);
    logic [N:0] c;
    logic [K-1:0] dd;
    int s;
    c = '0; dd = d; s = 0;
    for (int i = 0; i < int'(N); i++) begin
      if (((i + 1) & i) != 0) begin
        if (dd[0]) begin c = c | (CW'(1) << i); s = s ^ (i + 1); end
        dd = dd >> 1;
      end
    end
    for (int j = 0; j < int'(P); j++) if (((s >> j) & 1) != 0) c = c | (CW'(1) << ((1 << j) - 1));
    c[N] = ^c[N-1:0];
    return c;
  endfunction

  function automatic logic [N:0] mk_code(input int nerr);
    logic [N:0] c;
    int a, b;
    c = enc(K'($urandom));
    a = int'($urandom_range(0, N));
    b = (a + 1 + int'($urandom_range(0, N - 1))) % int'(N + 1);
    if (nerr >= 1) c = c ^ (CW'(1) << a);
    if (nerr >= 2) c = c ^ (CW'(1) << b);
    return c;
  endfunction

  task automatic drive(input logic v, input logic [N:0] c, input logic ordy,
                       input logic clr, input logic r);
    @(negedge clk);
    rst = r; in_valid = v; in_code = c; out_ready = ordy; clr_cnt = clr;
    #1;
  endtask

  // Records this cycle's handshakes into the model, then crosses the clock edge.
  task automatic tick(output logic dlv, output logic [RW-1:0] act,
                      output logic [RW:0] act2, output logic [RW-1:0] e);
    logic acc;
    dlv  = out_valid && out_ready && !rst;
    acc  = in_valid && in_ready && !rst;
    act  = {out_data, out_syndrome, out_sec, out_ded};
    act2 = {b_out_valid, b_out_data, b_out_syndrome, b_out_sec, b_out_ded};
    e    = 'x;
    if (rst) begin
      q.delete();
      m16_sec = 0; m16_ded = 0; m2_sec = 0; m2_ded = 0;
    end else begin
      if (dlv && q.size() > 0) e = q.pop_front();
      if (clr_cnt) begin
        m16_sec = 0; m16_ded = 0; m2_sec = 0; m2_ded = 0;
      end else if (dlv && !$isunknown(e)) begin
        if (e[1]) begin
          if (m16_sec < 65535) m16_sec++;
          if (m2_sec < 3) m2_sec++;
        end
        if (e[0]) begin
          if (m16_ded < 65535) m16_ded++;
          if (m2_ded < 3) m2_ded++;
        end
      end
      if (acc) q.push_back(ref_dec(in_code));
    end
    @(posedge clk);
  endtask

  task automatic test_reset();
    logic dlv; logic [RW-1:0] act, e; logic [RW:0] act2;
    drive(0, '0, 0, 0, 1); tick(dlv, act, act2, e);
    drive(0, '0, 0, 0, 1);
    checks++; if (in_ready !== 1'b0) $display("FAIL reset_in_ready got=%b want=0", in_ready); else passed++;
    checks++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid got=%b want=0", out_valid); else passed++;
    checks++;
    if ({out_data, out_syndrome, out_sec, out_ded} !== '0)
      $display("FAIL reset_outputs got=%h want=0", {out_data, out_syndrome, out_sec, out_ded});
    else passed++;
    checks++;
    if ({cnt_sec, cnt_ded, b_cnt_sec, b_cnt_ded} !== '0)
      $display("FAIL reset_counters got=%h/%h/%h/%h want=0", cnt_sec, cnt_ded, b_cnt_sec, b_cnt_ded);
    else passed++;
    tick(dlv, act, act2, e);
    drive(0, '0, 1, 0, 0); tick(dlv, act, act2, e);
    drive(0, '0, 1, 0, 0);
    checks++; if (in_ready !== 1'b1) $display("FAIL post_reset_in_ready got=%b want=1", in_ready); else passed++;
    tick(dlv, act, act2, e);
  endtask

  task automatic test_directed();
    logic dlv; logic [RW-1:0] act, e; logic [RW:0] act2;
    logic [N:0]    codes [4];
    logic [RW-1:0] expv  [4];
    logic [15:0]   exp_cs[4];
    logic [15:0]   exp_cd[4];
    codes[0] = 8'h55; expv[0] = {4'b1011, 3'b000, 1'b0, 1'b0}; exp_cs[0] = 0; exp_cd[0] = 0;
    codes[1] = 8'h45; expv[1] = {4'b1011, 3'b101, 1'b1, 1'b0}; exp_cs[1] = 1; exp_cd[1] = 0;
    codes[2] = 8'hD5; expv[2] = {4'b1011, 3'b000, 1'b1, 1'b0}; exp_cs[2] = 2; exp_cd[2] = 0;
    codes[3] = 8'h56; expv[3] = {4'b1011, 3'b011, 1'b0, 1'b1}; exp_cs[3] = 2; exp_cd[3] = 1;
    for (int t = 0; t < 4; t++) begin
      drive(1, codes[t], 1, 0, 0);
      checks++; if (in_ready !== 1'b1) $display("FAIL dir%0d_accept in_ready=%b want=1", t, in_ready); else passed++;
      tick(dlv, act, act2, e);
      drive(0, '0, 1, 0, 0);
      checks++; if (out_valid !== 1'b0) $display("FAIL dir%0d_early_valid got=%b want=0", t, out_valid); else passed++;
      tick(dlv, act, act2, e);
      drive(0, '0, 1, 0, 0);
      checks++; if (out_valid !== 1'b1) $display("FAIL dir%0d_latency got=%b want=1", t, out_valid); else passed++;
      checks++;
      if ({out_data, out_syndrome, out_sec, out_ded} !== expv[t])
        $display("FAIL dir%0d_result code=%h got=%b want=%b", t, codes[t],
                 {out_data, out_syndrome, out_sec, out_ded}, expv[t]);
      else passed++;
      tick(dlv, act, act2, e);
      drive(0, '0, 1, 0, 0);
      checks++;
      if (cnt_sec !== exp_cs[t] || cnt_ded !== exp_cd[t])
        $display("FAIL dir%0d_counters got=%0d/%0d want=%0d/%0d", t, cnt_sec, cnt_ded, exp_cs[t], exp_cd[t]);
      else passed++;
      tick(dlv, act, act2, e);
    end
  endtask

  task automatic test_random_stream(input int ncyc);
    logic dlv; logic [RW-1:0] act, e; logic [RW:0] act2;
    logic prev_stall;
    logic [RW-1:0] prev_out;
    logic exp_rdy;
    int r, nerr;
    prev_stall = 1'b0; prev_out = '0;
    for (int c = 0; c < ncyc + 12; c++) begin
      r = int'($urandom_range(0, 9));
      nerr = (r < 4) ? 0 : (r < 7) ? 1 : 2;
      if (c < ncyc)
        drive($urandom_range(0, 99) < 70, mk_code(nerr), $urandom_range(0, 99) < 60,
              $urandom_range(0, 99) < 2, 0);
      else
        drive(0, '0, 1, 0, 0);
      exp_rdy = (q.size() < 2) || out_ready;
      checks++;
      if (in_ready !== exp_rdy || b_in_ready !== exp_rdy)
        $display("FAIL rnd_in_ready cyc=%0d got=%b/%b want=%b", c, in_ready, b_in_ready, exp_rdy);
      else passed++;
      if (prev_stall) begin
        checks++;
        if (out_valid !== 1'b1 || {out_data, out_syndrome, out_sec, out_ded} !== prev_out)
          $display("FAIL rnd_hold cyc=%0d got=%b/%b want=1/%b", c, out_valid,
                   {out_data, out_syndrome, out_sec, out_ded}, prev_out);
        else passed++;
      end
      prev_stall = out_valid && !out_ready;
      prev_out   = {out_data, out_syndrome, out_sec, out_ded};
      tick(dlv, act, act2, e);
      if (dlv) begin
        checks++;
        if (act !== e || act2 !== {1'b1, e})
          $display("FAIL rnd_data cyc=%0d got=%b w2=%b want=%b", c, act, act2, e);
        else passed++;
      end
    end
    drive(0, '0, 1, 0, 0);
    checks++; if (q.size() != 0) $display("FAIL rnd_drain left=%0d want=0", q.size()); else passed++;
    checks++;
    if (cnt_sec !== 16'(m16_sec) || cnt_ded !== 16'(m16_ded) ||
        b_cnt_sec !== 2'(m2_sec) || b_cnt_ded !== 2'(m2_ded))
      $display("FAIL rnd_counters got=%0d/%0d/%0d/%0d want=%0d/%0d/%0d/%0d",
               cnt_sec, cnt_ded, b_cnt_sec, b_cnt_ded, m16_sec, m16_ded, m2_sec, m2_ded);
    else passed++;
    tick(dlv, act, act2, e);
  endtask

  task automatic test_backpressure();
    logic dlv; logic [RW-1:0] act, e; logic [RW:0] act2;
    logic [N:0] w[4];
    logic prev_stall;
    logic [RW-1:0] prev_out;
    int sent, got;
    for (int i = 0; i < 4; i++) w[i] = mk_code(i % 3);
    sent = 0; got = 0; prev_stall = 1'b0; prev_out = '0;
    for (int cyc = 0; cyc < 20 && got < 4; cyc++) begin
      drive(sent < 4, (sent < 4) ? w[sent] : '0, cyc >= 3, 0, 0);
      if (cyc == 2) begin
        checks++;
        if (in_ready !== 1'b0 || sent != 2)
          $display("FAIL bp_full in_ready=%b accepted=%0d want=0/2", in_ready, sent);
        else passed++;
      end
      if (prev_stall) begin
        checks++;
        if (out_valid !== 1'b1 || {out_data, out_syndrome, out_sec, out_ded} !== prev_out)
          $display("FAIL bp_hold cyc=%0d got=%b want=%b", cyc,
                   {out_data, out_syndrome, out_sec, out_ded}, prev_out);
        else passed++;
      end
      prev_stall = out_valid && !out_ready;
      prev_out   = {out_data, out_syndrome, out_sec, out_ded};
      if (in_valid && in_ready) sent++;
      tick(dlv, act, act2, e);
      if (dlv) begin
        got++;
        checks++;
        if (act !== e) $display("FAIL bp_order word=%0d got=%b want=%b", got, act, e); else passed++;
      end
    end
    checks++; if (got != 4) $display("FAIL bp_count delivered=%0d want=4", got); else passed++;
  endtask

  task automatic test_counters();
    logic dlv; logic [RW-1:0] act, e; logic [RW:0] act2;
    int sent, got;
    drive(0, '0, 1, 1, 0); tick(dlv, act, act2, e);
    drive(0, '0, 1, 0, 0);
    checks++;
    if (cnt_sec !== 16'd0 || b_cnt_sec !== 2'd0)
      $display("FAIL cnt_clear got=%0d/%0d want=0/0", cnt_sec, b_cnt_sec);
    else passed++;
    tick(dlv, act, act2, e);
    sent = 0; got = 0;
    for (int cyc = 0; cyc < 30 && got < 4; cyc++) begin
      drive(sent < 4, mk_code(1), 1, 0, 0);
      if (in_valid && in_ready) sent++;
      tick(dlv, act, act2, e);
      if (dlv) begin
        got++;
        checks++;
        if (act !== e) $display("FAIL cnt_word got=%b want=%b", act, e); else passed++;
      end
    end
    drive(0, '0, 1, 0, 0);
    checks++;
    if (b_cnt_sec !== 2'd3 || cnt_sec !== 16'd4)
      $display("FAIL cnt_saturate got=%0d/%0d want=3/4", b_cnt_sec, cnt_sec);
    else passed++;
    tick(dlv, act, act2, e);
    drive(1, mk_code(1), 1, 0, 0); tick(dlv, act, act2, e);
    drive(0, '0, 1, 0, 0); tick(dlv, act, act2, e);
    drive(0, '0, 1, 1, 0);
    checks++;
    if (out_valid !== 1'b1 || out_sec !== 1'b1)
      $display("FAIL cnt_clr_setup valid/sec=%b%b want=11", out_valid, out_sec);
    else passed++;
    tick(dlv, act, act2, e);
    drive(0, '0, 1, 0, 0);
    checks++;
    if (cnt_sec !== 16'd0 || b_cnt_sec !== 2'd0)
      $display("FAIL cnt_clr_wins got=%0d/%0d want=0/0", cnt_sec, b_cnt_sec);
    else passed++;
    tick(dlv, act, act2, e);
  endtask

  task automatic test_reset_midstream();
    logic dlv; logic [RW-1:0] act, e; logic [RW:0] act2;
    for (int i = 0; i < 3; i++) begin
      drive(1, mk_code(1), 0, 0, 0); tick(dlv, act, act2, e);
    end
    drive(1, mk_code(1), 1, 0, 1); tick(dlv, act, act2, e);
    drive(0, '0, 1, 0, 0);
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b0)
      $display("FAIL mid_reset valid/ready=%b%b want=00", out_valid, in_ready);
    else passed++;
    tick(dlv, act, act2, e);
    for (int i = 0; i < 5; i++) begin
      drive(0, '0, 1, 0, 0);
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1 || cnt_sec !== 16'd0 || cnt_ded !== 16'd0)
        $display("FAIL mid_reset_quiet cyc=%0d valid=%b ready=%b cnt=%0d/%0d want=0/1/0/0",
                 i, out_valid, in_ready, cnt_sec, cnt_ded);
      else passed++;
      tick(dlv, act, act2, e);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_backpressure();
    test_random_stream(400);
    test_counters();
    test_reset_midstream();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
